// File: rtl/ppc_muldiv_unit_pkg.sv
// Shared definitions for the PPC multiply/divide unit: op encodings, FSM states
// and small op-classification helpers.
package ppc_muldiv_unit_pkg;

  localparam int MDOp_WIDTH = 3;

  localparam logic [MDOp_WIDTH-1:0] MDOp_MULLW  = 3'd0;
  localparam logic [MDOp_WIDTH-1:0] MDOp_MULHW  = 3'd1;
  localparam logic [MDOp_WIDTH-1:0] MDOp_MULHWU = 3'd2;
  localparam logic [MDOp_WIDTH-1:0] MDOp_DIVW   = 3'd3;
  localparam logic [MDOp_WIDTH-1:0] MDOp_DIVWU  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_mul(input logic [MDOp_WIDTH-1:0] op);
    return op <= MDOp_MULHWU;
  endfunction

  function automatic logic op_is_div(input logic [MDOp_WIDTH-1:0] op);
    return (op == MDOp_DIVW) || (op == MDOp_DIVWU);
  endfunction

  // mullw is treated as signed so its overflow check sees the true signed product.
  function automatic logic op_is_signed(input logic [MDOp_WIDTH-1:0] op);
    return (op == MDOp_MULLW) || (op == MDOp_MULHW) || (op == MDOp_DIVW);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned radix-2 engine: shift-add multiply (LSB first) and restoring divide.
// After WIDTH steps {hi_o,lo_o} holds the product, or lo_o the quotient.
module muldiv_core
  import ppc_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] lo_init_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             finished_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, d_q;
  logic             div_q;

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Remainder stays below the divisor, so bit WIDTH of trial is the borrow.
  assign add_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, d_q}) : {1'b0, hi_q};
  assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, d_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      d_q   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= lo_init_i;
      d_q   <= d_i;
      div_q <= is_div_i;
    end else if (step_i) begin
      cnt_q <= cnt_q + 1'b1;
      if (div_q) begin
        if (!trial[WIDTH]) begin
          hi_q <= trial[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= rem_sh[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_q <= add_sum[WIDTH:1];
        lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  assign finished_o = (cnt_q == CNT_W'(WIDTH - 1));
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: rtl/ppc_muldiv_unit.sv
// Multi-cycle mullw/mulhw/mulhwu/divw/divwu unit with start/busy/done handshake.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply bypassing CALC.
// Bits are numbered [WIDTH-1:0] here; PPC bit 0 (MSB) is index WIDTH-1.
module ppc_muldiv_unit
  import ppc_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MDOp_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  input  logic                  XER_SO,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      C,
  output logic                  OV,
  output logic                  SO,
  output logic [3:0]            CR0,
  output md_state_e             dbg_state_o
);

  // Handshake: start is sampled only in IDLE; busy covers CALC/FIX/DONE; done
  // is a one-cycle pulse in DONE; flush while busy returns to IDLE with no done.
  md_state_e state_q, state_d;
  logic [MDOp_WIDTH-1:0] op_q;
  logic neg_q, so_in_q, eo_q;
  logic [WIDTH-1:0] c_q;
  logic ov_q, so_q;
  logic [3:0] cr0_q;

  logic accept, sgn, div_zero, divw_ovf, eo_ovf, early;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
  logic core_load, core_step, core_fin;

  assign accept   = (state_q == ST_IDLE) && start;
  assign sgn      = op_is_signed(op);
  assign a_mag    = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag    = (sgn && B[WIDTH-1]) ? -B : B;
  assign div_zero = (B == '0);
  assign divw_ovf = (op == MDOp_DIVW) && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  assign eo_ovf   = op_is_div(op) && (div_zero || divw_ovf);
`ifdef MULDIV_FAST_MUL_EN
  assign early    = (op > MDOp_DIVWU) || eo_ovf || op_is_mul(op);
`else
  assign early    = (op > MDOp_DIVWU) || eo_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = early ? ST_FIX : ST_CALC;
      ST_CALC: if (flush) state_d = ST_IDLE; else if (core_fin) state_d = ST_FIX;
      ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE) && !flush;
    core_load = accept;
    core_step = (state_q == ST_CALC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      neg_q   <= 1'b0;
      so_in_q <= 1'b0;
      eo_q    <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      neg_q   <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
      so_in_q <= XER_SO;
      eo_q    <= eo_ovf;
    end
  end

  muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (core_load),
    .step_i    (core_step),
    .is_div_i  (op_is_div(op)),
    .lo_init_i (op_is_div(op) ? a_mag : b_mag),
    .d_i       (op_is_div(op) ? b_mag : a_mag),
    .finished_o(core_fin),
    .hi_o      (core_hi),
    .lo_o      (core_lo)
  );

  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH-1:0]   quo, res_c;
  logic               res_ov, res_so;

`ifdef MULDIV_FAST_MUL_EN
  logic [WIDTH-1:0] a_mag_q, b_mag_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag_q <= '0;
      b_mag_q <= '0;
    end else if (accept) begin
      a_mag_q <= a_mag;
      b_mag_q <= b_mag;
    end
  end
  assign prod_u = {{WIDTH{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q};
`else
  assign prod_u = {core_hi, core_lo};
`endif

  assign prod_s = neg_q ? -prod_u : prod_u;
  assign quo    = neg_q ? -core_lo : core_lo;

  always_comb begin
    res_c  = '1;
    res_ov = 1'b0;
    if (op_q <= MDOp_DIVWU) begin
      if (eo_q) begin
        res_c  = '0;
        res_ov = 1'b1;
      end else if (op_q == MDOp_MULLW) begin
        res_c  = prod_s[WIDTH-1:0];
        res_ov = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
      end else if (op_is_mul(op_q)) begin
        res_c  = prod_s[2*WIDTH-1:WIDTH];
      end else begin
        res_c  = quo;
      end
    end
    res_so = so_in_q | res_ov;
  end

  // Results change only at a non-flushed FIX edge, so an abort keeps old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q   <= '0;
      ov_q  <= 1'b0;
      so_q  <= 1'b0;
      cr0_q <= '0;
    end else if ((state_q == ST_FIX) && !flush) begin
      c_q   <= res_c;
      ov_q  <= res_ov;
      so_q  <= res_so;
      cr0_q <= {res_c[WIDTH-1], !res_c[WIDTH-1] && (res_c != '0), res_c == '0, res_so};
    end
  end

  assign C           = c_q;
  assign OV          = ov_q;
  assign SO          = so_q;
  assign CR0         = cr0_q;
  assign dbg_state_o = state_q;

endmodule
